// File: rtl/l2_arb_pkg.sv
// Shared types and width helpers for the L2 TCDM arbiter.
// The widths derived here are reused by the top-level parameters.
package l2_arb_pkg;

   localparam int unsigned DefaultNumReq = 2;

   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int unsigned StarveCntW(input int unsigned limit);
      return $clog2(limit + 1);
   endfunction

   typedef logic [idx_width(DefaultNumReq)-1:0] idx_t;

endpackage

// File: rtl/fifo_v3.sv
// Small synchronous FIFO holding requester IDs of accepted, not yet answered requests.
// The head is read combinationally so responses route in the same cycle.
module fifo_v3 #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   output logic                  full_o,
   output logic                  empty_o,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  push_i,
   output logic [DATA_WIDTH-1:0] data_o,
   input  logic                  pop_i
);
   localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CntW = $clog2(DEPTH + 1);

   typedef logic [PtrW-1:0] ptr_t;
   localparam ptr_t LastPtr = ptr_t'(DEPTH - 1);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   ptr_t                  rd_ptr_q, wr_ptr_q;
   logic [CntW-1:0]       cnt_q;
   logic                  do_push, do_pop;

   assign full_o  = (cnt_q == CntW'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign data_o  = mem_q[rd_ptr_q];

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (do_push) wr_ptr_q <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
         if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
         else if (!do_push && do_pop) cnt_q <= cnt_q - 1'b1;
      end
   end

endmodule

// File: rtl/l2_tcdm_arbiter.sv
// Merges NumReq TCDM requesters onto one interconnect port: round-robin with a
// high-priority class, starvation forcing, and ID-tracked response routing.
module l2_tcdm_arbiter
   import l2_arb_pkg::*;
#(
   parameter int unsigned NumReq         = 2,
   parameter int unsigned AddrWidth      = 32,
   parameter int unsigned DataWidth      = 32,
   parameter int unsigned MaxOutstanding = 2,
   parameter int unsigned StarveLimit    = 16
) (
   input  logic                                clk_i,
   input  logic                                rst_ni,
   input  logic [NumReq-1:0]                   req_i,
   input  logic [NumReq-1:0][AddrWidth-1:0]    add_i,
   input  logic [NumReq-1:0]                   wen_i,
   input  logic [NumReq-1:0][DataWidth-1:0]    wdata_i,
   input  logic [NumReq-1:0][DataWidth/8-1:0]  be_i,
   input  logic [NumReq-1:0]                   hi_prio_i,
   output logic [NumReq-1:0]                   gnt_o,
   output logic [NumReq-1:0]                   r_valid_o,
   output logic [NumReq-1:0][DataWidth-1:0]    r_rdata_o,
   output logic                                m_req_o,
   output logic [AddrWidth-1:0]                m_add_o,
   output logic                                m_wen_o,
   output logic [DataWidth-1:0]                m_wdata_o,
   output logic [DataWidth/8-1:0]              m_be_o,
   input  logic                                m_gnt_i,
   input  logic                                m_r_valid_i,
   input  logic [DataWidth-1:0]                m_r_rdata_i,
   output logic                                err_o
);
   localparam int unsigned IdxW = idx_width(NumReq);
   localparam int unsigned CntW = StarveCntW(StarveLimit);

   typedef logic [IdxW-1:0] req_idx_t;
   typedef logic [CntW-1:0] cnt_t;
   localparam cnt_t CntMax = cnt_t'(StarveLimit);

   req_idx_t                rr_ptr_q, winner, head;
   logic                    found, fifo_full, fifo_empty, hs, pop;
   logic [NumReq-1:0]       eligible;
   logic [NumReq-1:0][CntW-1:0] starve_cnt_q;
   logic                    err_q;

   assign eligible = req_i & ~{NumReq{fifo_full}};

   // Starved requesters first, then high class, then low class, both from rr_ptr.
   always_comb begin
      req_idx_t cand;
      winner = '0;
      found  = 1'b0;
      cand   = '0;
      for (int i = 0; i < NumReq; i++) begin
         if (!found && eligible[i] && starve_cnt_q[i] == CntMax) begin
            winner = req_idx_t'(i);
            found  = 1'b1;
         end
      end
      for (int cls = 1; cls >= 0; cls--) begin
         for (int off = 0; off < NumReq; off++) begin
            cand = req_idx_t'((32'(rr_ptr_q) + 32'(off)) % NumReq);
            if (!found && eligible[cand] && (hi_prio_i[cand] == (cls == 1))) begin
               winner = cand;
               found  = 1'b1;
            end
         end
      end
   end

   assign m_req_o   = found;
   assign m_add_o   = found ? add_i[winner]   : '0;
   assign m_wen_o   = found ? wen_i[winner]   : 1'b0;
   assign m_wdata_o = found ? wdata_i[winner] : '0;
   assign m_be_o    = found ? be_i[winner]    : '0;
   assign hs        = m_req_o && m_gnt_i;
   assign pop       = m_r_valid_i && !fifo_empty;
   assign err_o     = err_q;

   for (genvar gi = 0; gi < NumReq; gi++) begin : g_req
      assign gnt_o[gi]     = hs && (winner == req_idx_t'(gi));
      assign r_valid_o[gi] = pop && (head == req_idx_t'(gi));
      assign r_rdata_o[gi] = m_r_rdata_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_ptr_q     <= '0;
         starve_cnt_q <= '0;
         err_q        <= 1'b0;
      end else begin
         if (hs) rr_ptr_q <= (winner == req_idx_t'(NumReq - 1)) ? '0 : winner + 1'b1;
         for (int i = 0; i < NumReq; i++) begin
            if (gnt_o[i])
               starve_cnt_q[i] <= '0;
            else if (req_i[i] && starve_cnt_q[i] != CntMax)
               starve_cnt_q[i] <= starve_cnt_q[i] + 1'b1;
         end
         if (m_r_valid_i && fifo_empty) err_q <= 1'b1;
      end
   end

   fifo_v3 #(
      .DATA_WIDTH (IdxW),
      .DEPTH      (MaxOutstanding)
   ) i_id_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .data_i  (winner),
      .push_i  (hs),
      .data_o  (head),
      .pop_i   (pop)
   );

endmodule

// File: tb/tb_l2_tcdm_arbiter.sv
// Directed bench for l2_tcdm_arbiter with default parameters (2 requesters,
// 2 outstanding, starvation limit 16); expected values are hand-derived.
module tb_l2_tcdm_arbiter;
   localparam int N  = 2;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam logic [AW-1:0] ADDR0 = 32'h1000_0000;
   localparam logic [AW-1:0] ADDR1 = 32'h2000_0004;

   logic                   clk_i = 1'b0;
   logic                   rst_ni;
   logic [N-1:0]           req_i, wen_i, hi_prio_i;
   logic [N-1:0][AW-1:0]   add_i;
   logic [N-1:0][DW-1:0]   wdata_i;
   logic [N-1:0][DW/8-1:0] be_i;
   logic [N-1:0]           gnt_o, r_valid_o;
   logic [N-1:0][DW-1:0]   r_rdata_o;
   logic                   m_req_o, m_wen_o, m_gnt_i, m_r_valid_i, err_o;
   logic [AW-1:0]          m_add_o;
   logic [DW-1:0]          m_wdata_o, m_r_rdata_i;
   logic [DW/8-1:0]        m_be_o;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk_i = ~clk_i;

   l2_tcdm_arbiter dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .add_i(add_i), .wen_i(wen_i),
      .wdata_i(wdata_i), .be_i(be_i), .hi_prio_i(hi_prio_i), .gnt_o(gnt_o),
      .r_valid_o(r_valid_o), .r_rdata_o(r_rdata_o), .m_req_o(m_req_o), .m_add_o(m_add_o),
      .m_wen_o(m_wen_o), .m_wdata_o(m_wdata_o), .m_be_o(m_be_o), .m_gnt_i(m_gnt_i),
      .m_r_valid_i(m_r_valid_i), .m_r_rdata_i(m_r_rdata_i), .err_o(err_o)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
      end else begin
         $display("[TB] ok   %s = %0h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      req_i       = '0;
      hi_prio_i   = '0;
      m_gnt_i     = 1'b0;
      m_r_valid_i = 1'b0;
      m_r_rdata_i = '0;
      rst_ni      = 1'b0;
      tick();
      tick();
      rst_ni = 1'b1;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [N-1:0]  exp_g, prev_g;
      logic [DW-1:0] rd;

      add_i[0] = ADDR0;  add_i[1] = ADDR1;
      wen_i    = 2'b10;
      wdata_i[0] = 32'hDEAD_0000;  wdata_i[1] = 32'hBEEF_1111;
      be_i[0]  = 4'hF;  be_i[1] = 4'h3;

      // Reset state
      do_reset();
      #1;
      chk("rst m_req", m_req_o, 1'b0);
      chk("rst gnt", gnt_o, 2'b00);
      chk("rst r_valid", r_valid_o, 2'b00);
      chk("rst err", err_o, 1'b0);
      chk("rst m_add", m_add_o, 32'h0);
      chk("rst m_wdata", m_wdata_o, 32'h0);

      // Basic round-robin with a 1-cycle response model
      req_i = 2'b11; m_gnt_i = 1'b1; prev_g = 2'b00;
      for (int c = 0; c < 6; c++) begin
         exp_g = (c % 2 == 0) ? 2'b01 : 2'b10;
         rd = 32'hA000_0000 + 32'(c);
         m_r_valid_i = (c > 0); m_r_rdata_i = rd;
         #1;
         chk($sformatf("rr gnt c%0d", c), gnt_o, exp_g);
         chk($sformatf("rr m_add c%0d", c), m_add_o, (c % 2 == 0) ? ADDR0 : ADDR1);
         chk($sformatf("rr m_wen c%0d", c), m_wen_o, (c % 2 == 0) ? 1'b0 : 1'b1);
         chk($sformatf("rr r_valid c%0d", c), r_valid_o, prev_g);
         if (c > 0) chk($sformatf("rr rdata c%0d", c), r_rdata_o[(c - 1) % 2], rd);
         prev_g = exp_g;
         tick();
      end
      req_i = 2'b00; m_r_valid_i = 1'b1;
      #1;
      chk("rr drain r_valid", r_valid_o, 2'b10);
      chk("rr drain m_req", m_req_o, 1'b0);
      tick();
      m_r_valid_i = 1'b0;
      #1;
      chk("rr err stays low", err_o, 1'b0);

      // High priority with starvation forcing
      do_reset();
      req_i = 2'b11; hi_prio_i = 2'b10; m_gnt_i = 1'b1; prev_g = 2'b00;
      for (int c = 0; c < 18; c++) begin
         exp_g = (c == 16) ? 2'b01 : 2'b10;
         m_r_valid_i = (c > 0);
         #1;
         chk($sformatf("prio gnt c%0d", c), gnt_o, exp_g);
         chk($sformatf("prio r_valid c%0d", c), r_valid_o, prev_g);
         prev_g = exp_g;
         tick();
      end

      // FIFO full: responses withheld
      do_reset();
      req_i = 2'b11; m_gnt_i = 1'b1;
      #1; chk("full gnt c0", gnt_o, 2'b01); tick();
      #1; chk("full gnt c1", gnt_o, 2'b10); tick();
      #1; chk("full m_req c2", m_req_o, 1'b0); chk("full gnt c2", gnt_o, 2'b00); tick();
      m_r_valid_i = 1'b1; m_r_rdata_i = 32'h5555_AAAA;
      #1;
      chk("full m_req on pop", m_req_o, 1'b0);
      chk("full r_valid on pop", r_valid_o, 2'b01);
      chk("full rdata on pop", r_rdata_o[0], 32'h5555_AAAA);
      tick();
      m_r_valid_i = 1'b0;
      #1; chk("full gnt after pop", gnt_o, 2'b01); tick();
      #1; chk("full m_req refilled", m_req_o, 1'b0);

      // Backpressure: no grant for 5 cycles
      do_reset();
      req_i = 2'b11; m_gnt_i = 1'b0;
      for (int c = 0; c < 5; c++) begin
         #1;
         chk($sformatf("bp gnt c%0d", c), gnt_o, 2'b00);
         chk($sformatf("bp m_req c%0d", c), m_req_o, 1'b1);
         tick();
      end
      chk("bp starve0", dut.starve_cnt_q[0], 5);
      chk("bp starve1", dut.starve_cnt_q[1], 5);
      m_gnt_i = 1'b1;
      #1; chk("bp first gnt", gnt_o, 2'b01); tick();
      #1; chk("bp second gnt", gnt_o, 2'b10); tick();
      #1; chk("bp fifo full", m_req_o, 1'b0);

      // Protocol error: response with empty FIFO
      do_reset();
      m_r_valid_i = 1'b1;
      #1;
      chk("err r_valid", r_valid_o, 2'b00);
      chk("err same cycle", err_o, 1'b0);
      tick();
      m_r_valid_i = 1'b0;
      #1; chk("err raised", err_o, 1'b1);
      tick(); tick(); tick();
      chk("err sticky", err_o, 1'b1);
      rst_ni = 1'b0;
      #1; chk("err cleared by reset", err_o, 1'b0);

      // Reset with two transactions outstanding
      do_reset();
      req_i = 2'b11; m_gnt_i = 1'b1;
      tick(); tick();
      req_i = 2'b00; rst_ni = 1'b0;
      tick();
      rst_ni = 1'b1;
      #1;
      chk("mid rst err", err_o, 1'b0);
      chk("mid rst m_req idle", m_req_o, 1'b0);
      req_i = 2'b11;
      #1; chk("mid rst gnt0", gnt_o, 2'b01); tick();
      #1; chk("mid rst gnt1", gnt_o, 2'b10); tick();
      #1; chk("mid rst full", m_req_o, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
